wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the pipeline writeback path (MEM/WB stage output) and the IP-mode accelerator result port. Pipeline writebacks normally win. Accelerator results are buffered in a small FIFO and written back when the port is idle, when the FIFO is full, or when the oldest entry has waited too long. Whenever the accelerator takes the port while a writeback is pending, the block asserts `stall`, which drives the MEM/WB hold-enable so that stage keeps its contents for that cycle.

## Interface
- `DEPTH`, 2: IP result FIFO entries; power of two, ≥2.
- `MAX_WAIT`, 4: cycles the FIFO head may be passed over before it is forced onto the port; 1..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_valid`  in  1  MEM/WB stage holds a writeback this cycle.
- `wb_addr`  in  5  writeback destination register.
- `wb_data`  in  32  writeback data.
- `ip_req`  in  1  accelerator offers a result.
- `ip_addr`  in  5  accelerator destination register.
- `ip_data`  in  32  accelerator result.
- `ip_ack`  out  1  combinational; the offered result is accepted at this edge.
- `stall`  out  1  combinational; 1 makes MEM/WB hold (drives its data-enable).
- `rf_we`  out  1  registered register-file write enable.
- `rf_addr`  out  5  registered write address.
- `rf_data`  out  32  registered write data.

## Operation
- **FIFO**
  - Holds `{addr, data}` entries, with `count` in 0..DEPTH.
  - Push: `ip_ack = ip_req & (count != DEPTH) & !rst`.
  - A push is refused when `count == DEPTH`, even if a pop occurs in the same cycle.
  - Pop happens on an IP grant.
  - Read and write pointers wrap modulo DEPTH.
- **Grant decision** (combinational, evaluated every cycle):
  - Grant IP if `count != 0` and any of the following holds:
    - `wb_valid == 0`
    - `count == DEPTH`
    - `wait_cnt == MAX_WAIT`
    - `wb_addr` matches the address of any valid FIFO entry (older IP results drain before a younger writeback to the same register).
  - Otherwise grant WB if `wb_valid`.
  - Otherwise grant nothing.
- **Stall:** `stall = wb_valid & IP grant`. While `stall` is high, the writeback is not consumed and is re-presented next cycle.
- **wait_cnt**
  - Clears on an IP grant or when `count == 0`.
  - Increments, saturating at MAX_WAIT, when `count != 0` and WB is granted.
- **Register-file outputs:** the granted entry is registered onto `rf_addr`/`rf_data` with `rf_we = 1`.
- **Register 0:** a grant with destination 0 still consumes the entry or writeback, but `rf_we = 0`.
- **No grant:** `rf_we = 0`; `rf_addr`/`rf_data` hold their previous values.
- **State summary:** IDLE (`count = 0`), BUFFERED (`0 < count < DEPTH`), FULL (`count = DEPTH`). Transitions follow push/pop: +1 on push only, −1 on pop only, unchanged on both or neither.

## Timing
- Grant-to-write latency is 1 cycle: the register-file write appears on the edge after the grant cycle.
- An accepted `ip_req` enters the FIFO at the edge. It can be granted at the earliest in the following cycle, so a result reaches the register file after a minimum of 2 edges.
- Worst-case IP wait is MAX_WAIT WB grants, then a forced grant.
- `stall` and `ip_ack` are valid in the same cycle as their inputs and have no registered delay.
- **Reset values:**
  - Outputs: `rf_we = 0`, `rf_addr = 0`, `rf_data = 0`, `stall = 0`, `ip_ack = 0`.
  - Internal state: FIFO empty, pointers 0, `wait_cnt = 0`.
- **Reset mid-operation:** buffered IP results are discarded, and a write already registered on `rf_*` is dropped immediately (`rf_we` goes to 0 asynchronously).

## Test plan
- **Reset:** assert `rst` mid-stream with 2 entries buffered → `rf_we = 0`, `rf_addr = 0`, `rf_data = 0`, `stall = 0`, `ip_ack = 0` immediately; after release, `count = 0` and no stale write occurs.
- **Idle IP path:** `wb_valid = 0`; push `ip_addr = 7`, `ip_data = 0xDEADBEEF` → `ip_ack = 1`; two edges later `rf_we = 1`, `rf_addr = 7`, `rf_data = 0xDEADBEEF`; `stall` stays 0.
- **Starvation:** `wb_valid` held at 1 with distinct addresses, one IP entry with `ip_addr = 9`, `MAX_WAIT = 4` → 4 WB writes, then `stall = 1` for one cycle and the IP write to r9, then the stalled writeback is written the next cycle.
- **Full FIFO:** 2 entries buffered and `wb_valid = 1` → `stall = 1` and an IP write; a third `ip_req` in that same cycle sees `ip_ack = 0`, then `ip_ack = 1` one cycle later.
- **Address hazard:** buffered IP to r5 with `wb_valid = 1`, `wb_addr = 5` → IP write to r5 first with `stall = 1`, WB write to r5 on the next cycle.
- **Register 0:** `wb_valid = 1`, `wb_addr = 0`, `wb_data = 0x1234` → entry consumed, `rf_we = 0`, `stall = 0`.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks normally win, while accelerator
// results are buffered and drained when the port is idle, the buffer is full, a hazard exists, or the head has waited too long.
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ip_req,
    input  logic [4:0]  ip_addr,
    input  logic [31:0] ip_data,
    output logic        ip_ack,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUFFERED = 2'd1,
        FULL     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic [31:0]       rf_data_q, rf_data_d;

    logic [4:0]        addr_mem_q [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];

    logic              push, pop, hazard, ip_gnt, wb_gnt;

    // Arbitration, FIFO bookkeeping and next-state logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        vld_d     = vld_q;
        wait_d    = wait_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        hazard    = 1'b0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[PW'(i)] && (addr_mem_q[PW'(i)] == wb_addr)) begin
                hazard = 1'b1;
            end
        end

        push   = ip_req && (state_q != FULL) && !rst;
        ip_gnt = (state_q != IDLE) &&
                 (!wb_valid || (state_q == FULL) || (wait_q == WAIT_MAX) || hazard);
        wb_gnt = wb_valid && !ip_gnt;
        pop    = ip_gnt;
        ip_ack = push;
        stall  = wb_valid && ip_gnt;

        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (count_d == '0) begin
            state_d = IDLE;
        end else if (count_d == FULL_CNT) begin
            state_d = FULL;
        end else begin
            state_d = BUFFERED;
        end

        if (ip_gnt || (state_q == IDLE)) begin
            wait_d = '0;
        end else if (wb_gnt && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WW'(1);
        end

        // Destination r0 still consumes the grant but never writes
        if (ip_gnt) begin
            rf_addr_d = addr_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
            rf_we_d   = (addr_mem_q[rd_ptr_q] != 5'd0);
        end else if (wb_gnt) begin
            rf_addr_d = wb_addr;
            rf_data_d = wb_data;
            rf_we_d   = (wb_addr != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            vld_q     <= '0;
            wait_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            vld_q     <= vld_d;
            wait_q    <= wait_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= ip_addr;
            data_mem_q[wr_ptr_q] <= ip_data;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected register-file writes are queued as
// stimulus is driven and popped as the DUT writes; handshake outputs are checked per cycle.
module tb_wb_port_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ip_req;
    logic [4:0]  ip_addr;
    logic [31:0] ip_data;
    logic        ip_ack;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_tests = 0;
    int n_fail  = 0;
    wr_t exp_q[$];

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ip_req   (ip_req),
        .ip_addr  (ip_addr),
        .ip_data  (ip_data),
        .ip_ack   (ip_ack),
        .stall    (stall),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic drive_ip(input logic r, input logic [4:0] a, input logic [31:0] d);
        ip_req  = r;
        ip_addr = a;
        ip_data = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle_drain(input string tag, input int n);
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_ip(1'b0, 5'd0, 32'd0);
        repeat (n) tick();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Write monitor: every DUT write must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", 64'(rf_we), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(rf_addr), 64'(e.addr));
                check("wr_data", 64'(rf_data), 64'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive_wb(1'b1, 5'd3, 32'h3);
        drive_ip(1'b1, 5'd4, 32'h4);
        #2;
        check("rst_rf_we",   64'(rf_we),   64'd0);
        check("rst_rf_addr", 64'(rf_addr), 64'd0);
        check("rst_rf_data", 64'(rf_data), 64'd0);
        check("rst_stall",   64'(stall),   64'd0);
        check("rst_ip_ack",  64'(ip_ack),  64'd0);
        repeat (2) tick();
        rst = 1'b0;
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_ip(1'b0, 5'd0, 32'd0);
        tick();

        // Idle IP path: two edges from offer to write
        drive_ip(1'b1, 5'd7, 32'hDEADBEEF);
        expect_wr(5'd7, 32'hDEADBEEF);
        @(negedge clk);
        check("idle_ack",   64'(ip_ack), 64'd1);
        check("idle_stall", 64'(stall),  64'd0);
        tick();
        drive_ip(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("idle_we_early", 64'(rf_we), 64'd0);
        check("idle_stall1",   64'(stall), 64'd0);
        tick();
        @(negedge clk);
        check("idle_we", 64'(rf_we), 64'd1);
        idle_drain("idle_left", 3);

        // Starvation: head passed over MAX_WAIT times, then forced
        drive_ip(1'b1, 5'd9, 32'h9999_0009);
        @(negedge clk);
        check("starve_ack", 64'(ip_ack), 64'd1);
        tick();
        drive_ip(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            drive_wb(1'b1, 5'(i), 32'h1000 + 32'(i));
            expect_wr(5'(i), 32'h1000 + 32'(i));
            @(negedge clk);
            check("starve_nostall", 64'(stall), 64'd0);
            tick();
        end
        drive_wb(1'b1, 5'd5, 32'h1005);
        expect_wr(5'd9, 32'h9999_0009);
        @(negedge clk);
        check("starve_stall", 64'(stall), 64'd1);
        tick();
        expect_wr(5'd5, 32'h1005);
        @(negedge clk);
        check("starve_release", 64'(stall), 64'd0);
        tick();
        idle_drain("starve_left", 3);

        // Full FIFO: forced drain and refused push in the same cycle
        drive_ip(1'b1, 5'd10, 32'hA10);
        drive_wb(1'b1, 5'd20, 32'h20);
        expect_wr(5'd20, 32'h20);
        @(negedge clk);
        check("full_ack0", 64'(ip_ack), 64'd1);
        tick();
        drive_ip(1'b1, 5'd11, 32'hA11);
        drive_wb(1'b1, 5'd21, 32'h21);
        expect_wr(5'd21, 32'h21);
        @(negedge clk);
        check("full_ack1",   64'(ip_ack), 64'd1);
        check("full_stall1", 64'(stall),  64'd0);
        tick();
        drive_ip(1'b1, 5'd12, 32'hA12);
        drive_wb(1'b1, 5'd22, 32'h22);
        expect_wr(5'd10, 32'hA10);
        @(negedge clk);
        check("full_stall", 64'(stall),  64'd1);
        check("full_nack",  64'(ip_ack), 64'd0);
        tick();
        expect_wr(5'd22, 32'h22);
        @(negedge clk);
        check("full_ack_retry", 64'(ip_ack), 64'd1);
        check("full_stall3",    64'(stall),  64'd0);
        tick();
        drive_ip(1'b0, 5'd0, 32'd0);
        drive_wb(1'b1, 5'd23, 32'h23);
        expect_wr(5'd11, 32'hA11);
        @(negedge clk);
        check("full_stall4", 64'(stall), 64'd1);
        tick();
        expect_wr(5'd23, 32'h23);
        @(negedge clk);
        check("full_stall5", 64'(stall), 64'd0);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        expect_wr(5'd12, 32'hA12);
        tick();
        idle_drain("full_left", 3);

        // Address hazard: older IP result to r5 drains before the writeback
        drive_ip(1'b1, 5'd5, 32'h55);
        drive_wb(1'b1, 5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        @(negedge clk);
        check("haz_stall0", 64'(stall), 64'd0);
        tick();
        drive_ip(1'b0, 5'd0, 32'd0);
        drive_wb(1'b1, 5'd5, 32'h5B);
        expect_wr(5'd5, 32'h55);
        @(negedge clk);
        check("haz_stall", 64'(stall), 64'd1);
        tick();
        expect_wr(5'd5, 32'h5B);
        @(negedge clk);
        check("haz_release", 64'(stall), 64'd0);
        tick();
        idle_drain("haz_left", 3);

        // Register 0: consumed without a write
        drive_wb(1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        check("r0_stall", 64'(stall), 64'd0);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("r0_we", 64'(rf_we), 64'd0);
        tick();
        idle_drain("r0_left", 2);

        // Reset mid-operation with two entries buffered and a write in flight
        drive_ip(1'b1, 5'd13, 32'hA13);
        drive_wb(1'b1, 5'd24, 32'h24);
        expect_wr(5'd24, 32'h24);
        tick();
        drive_ip(1'b1, 5'd14, 32'hA14);
        drive_wb(1'b1, 5'd25, 32'h25);
        tick();
        #1;
        rst = 1'b1;
        #1;
        check("mrst_rf_we",   64'(rf_we),   64'd0);
        check("mrst_rf_addr", 64'(rf_addr), 64'd0);
        check("mrst_rf_data", 64'(rf_data), 64'd0);
        check("mrst_stall",   64'(stall),   64'd0);
        check("mrst_ip_ack",  64'(ip_ack),  64'd0);
        tick();
        rst = 1'b0;
        drive_ip(1'b1, 5'd27, 32'h27);
        drive_wb(1'b1, 5'd26, 32'h26);
        expect_wr(5'd26, 32'h26);
        @(negedge clk);
        check("mrst_empty_stall", 64'(stall),  64'd0);
        check("mrst_ack",         64'(ip_ack), 64'd1);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_ip(1'b0, 5'd0, 32'd0);
        expect_wr(5'd27, 32'h27);
        idle_drain("mrst_left", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
